// File: rtl/port_rx_reader.sv
// Switch output-port reader: parses DA/SA/LEN/payload/FCS and streams payload out.
// Payload appears 1 cycle after a port byte is consumed; read is held off while the output register is full.
module port_rx_reader #(
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [7:0]       port_data,
  output logic             read,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [7:0]       pkt_da,
  output logic [7:0]       pkt_sa,
  output logic [7:0]       pkt_len,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DA, S_SA, S_LEN, S_DATA, S_FCS, S_DRAIN, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      da, sa, len, cnt, fcs;
  logic [TO_W-1:0] to_cnt;
  logic            take, in_pkt, timeout, len_bad, fcs_bad, finish, err_now;

  assign take    = read & ready;
  assign in_pkt  = state inside {S_DA, S_SA, S_LEN, S_DATA, S_FCS};
  assign len_bad = (port_data == 8'd0) || (int'(port_data) > MAX_LEN);
  assign fcs_bad = (port_data != fcs);
  assign finish  = (state_nxt == S_DONE) && (state != S_DONE);
  assign err_now = timeout || (state == S_DRAIN) || ((state == S_FCS) && fcs_bad);

  always_comb begin
    state_nxt = state;
    read      = 1'b0;
    pkt_done  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE:  if (ready) state_nxt = S_DA;
      S_DA:    begin read = 1'b1; if (ready) state_nxt = S_SA; end
      S_SA:    begin read = 1'b1; if (ready) state_nxt = S_LEN; end
      S_LEN: begin
        read = 1'b1;
        if (ready) state_nxt = len_bad ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        // only pull a byte when the output register has room this cycle
        read = !out_valid || out_ready;
        if (read && ready && cnt == 8'd1) state_nxt = S_FCS;
      end
      S_FCS:   begin read = 1'b1; if (ready) state_nxt = S_DONE; end
      S_DRAIN: begin read = 1'b1; if (!ready) state_nxt = S_DONE; end
      S_DONE:  begin pkt_done = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
    if (in_pkt && read && !ready && to_cnt == TO_W'(TIMEOUT - 1)) begin
      timeout   = 1'b1;
      state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      da        <= 8'd0;
      sa        <= 8'd0;
      len       <= 8'd0;
      cnt       <= 8'd0;
      fcs       <= 8'd0;
      to_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
      pkt_da    <= 8'd0;
      pkt_sa    <= 8'd0;
      pkt_len   <= 8'd0;
      pkt_err   <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;

      if (!in_pkt || take || timeout) to_cnt <= '0;
      else if (read && !ready)        to_cnt <= to_cnt + TO_W'(1);

      case (state)
        S_IDLE: begin
          da  <= 8'd0;
          sa  <= 8'd0;
          len <= 8'd0;
          fcs <= 8'd0;
        end
        S_DA:  if (take) begin da <= port_data; fcs <= port_data; end
        S_SA:  if (take) begin sa <= port_data; fcs <= fcs ^ port_data; end
        S_LEN: if (take) begin
          len <= port_data;
          cnt <= port_data;
          fcs <= fcs ^ port_data;
        end
        S_DATA: if (take) begin
          cnt <= cnt - 8'd1;
          fcs <= fcs ^ port_data;
        end
        default: ;
      endcase

      if (state == S_DATA && take) begin
        out_valid <= 1'b1;
        out_data  <= port_data;
        out_last  <= (cnt == 8'd1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (timeout && out_valid) begin
        // close a truncated payload on the byte still waiting downstream
        out_last <= 1'b1;
      end

      if (finish) begin
        pkt_da  <= da;
        pkt_sa  <= sa;
        pkt_len <= len;
        pkt_err <= err_now;
        if (err_now) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end else begin
          if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
      end else if (state == S_DONE) begin
        pkt_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_port_rx_reader.sv
// Directed bench for port_rx_reader: a port-side byte feeder, a payload/pkt_done monitor,
// and hand-computed expectations per packet.
module tb_port_rx_reader;

  logic        clk = 1'b0;
  logic        reset, ready, read, out_valid, out_ready, out_last, pkt_done, pkt_err;
  logic [7:0]  port_data, out_data, pkt_da, pkt_sa, pkt_len;
  logic [15:0] pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  port_rx_reader #(.MAX_LEN(255), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ready(ready), .port_data(port_data), .read(read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pkt_da(pkt_da), .pkt_sa(pkt_sa), .pkt_len(pkt_len), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  int          n_checks = 0;
  int          n_bad = 0;
  logic [7:0]  feed_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  out_q[$];
  logic        last_q[$];
  int          feed_idx = 0;
  bit          abort_feed = 0;
  int          done_cnt = 0, ov_seen = 0, stall_cnt = 0, blocked = 0;
  logic        snap_err = 1'b0;
  logic [7:0]  snap_da = 8'd0, snap_sa = 8'd0, snap_len = 8'd0;
  logic [15:0] snap_pc = 16'd0, snap_ec = 16'd0;
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_data = 8'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hold_prev && !reset) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, hold_data);
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (out_valid) ov_seen++;
    if (read && !ready) stall_cnt++;
    if (ready && !read && out_valid && !out_ready) blocked++;
    if (pkt_done) begin
      done_cnt++;
      snap_err = pkt_err;
      snap_da  = pkt_da;
      snap_sa  = pkt_sa;
      snap_len = pkt_len;
      snap_pc  = pkt_cnt;
      snap_ec  = err_cnt;
    end
  end

  task automatic start_test();
    out_q.delete();
    last_q.delete();
    exp_q.delete();
    done_cnt   = 0;
    ov_seen    = 0;
    stall_cnt  = 0;
    blocked    = 0;
    feed_idx   = 0;
    abort_feed = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // present feed_q one byte per cycle; a byte advances only when read & ready at the edge
  task automatic feed();
    feed_idx = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (abort_feed || feed_idx >= feed_q.size()) begin
        ready = 1'b0;
        return;
      end
      ready     = 1'b1;
      port_data = feed_q[feed_idx];
      @(negedge clk);
      if (read && ready) feed_idx++;
    end
    ready = 1'b0;
    check_eq("feed_budget", feed_idx, feed_q.size());
  endtask

  task automatic wait_done(input int target);
    for (int cyc = 0; cyc < 100 && done_cnt < target; cyc++) begin
      @(posedge clk); #2;
    end
    repeat (3) @(posedge clk);
    #2;
    check_eq("done_pulses", done_cnt, target);
  endtask

  task automatic check_pkt(input logic err, input logic [7:0] da, input logic [7:0] sa,
                           input logic [7:0] len, input int pc, input int ec);
    check_eq("pkt_err", snap_err, err);
    check_eq("pkt_da", snap_da, da);
    check_eq("pkt_sa", snap_sa, sa);
    check_eq("pkt_len", snap_len, len);
    check_eq("pkt_cnt", snap_pc, pc);
    check_eq("err_cnt", snap_ec, ec);
  endtask

  task automatic check_out();
    check_eq("out_count", out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check_eq("out_byte", out_q[i], exp_q[i]);
      check_eq("out_last", last_q[i], (i == exp_q.size() - 1));
    end
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; port_data = 8'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctl", {read, out_valid, out_last, pkt_done, pkt_err}, 0);
    check_eq("rst_dat", {out_data, pkt_da, pkt_sa, pkt_len}, 0);
    check_eq("rst_cnt", {pkt_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // good single-byte packet
    start_test();
    feed_q = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'hA8};
    exp_q  = '{8'hAA};
    feed();
    wait_done(1);
    check_pkt(1'b0, 8'h01, 8'h02, 8'h01, 1, 0);
    check_out();

    // bad FCS: payload still delivered
    do_reset();
    start_test();
    feed_q = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h00};
    exp_q  = '{8'hAA};
    feed();
    wait_done(1);
    check_pkt(1'b1, 8'h01, 8'h02, 8'h01, 0, 1);
    check_out();

    // downstream stall mid-payload
    do_reset();
    start_test();
    feed_q = '{8'h03, 8'h04, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h43};
    exp_q  = '{8'h10, 8'h20, 8'h30, 8'h40};
    fork
      feed();
      begin
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done(1);
    check_pkt(1'b0, 8'h03, 8'h04, 8'h04, 1, 0);
    check_out();
    check_eq("read_held_off", (blocked >= 4), 1);

    // LEN=0 drains until ready drops
    do_reset();
    start_test();
    feed_q = '{8'h05, 8'h06, 8'h00, 8'h11, 8'h22, 8'h33};
    feed();
    wait_done(1);
    check_pkt(1'b1, 8'h05, 8'h06, 8'h00, 0, 1);
    check_eq("drain_no_valid", ov_seen, 0);

    // ready drops after SA: timeout after exactly 16 stalled cycles
    do_reset();
    start_test();
    feed_q = '{8'h07, 8'h08};
    feed();
    wait_done(1);
    check_pkt(1'b1, 8'h07, 8'h08, 8'h00, 0, 1);
    check_eq("timeout_stalls", stall_cnt, 16);
    check_eq("timeout_read", read, 0);

    start_test();
    feed_q = '{8'h09, 8'h0A, 8'h02, 8'h5A, 8'hA5, 8'hFE};
    exp_q  = '{8'h5A, 8'hA5};
    feed();
    wait_done(1);
    check_pkt(1'b0, 8'h09, 8'h0A, 8'h02, 1, 1);
    check_out();

    // reset while payload byte 2 of a LEN=3 packet is on the port
    start_test();
    feed_q = '{8'h0B, 8'h0C, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    fork
      feed();
      begin
        for (int cyc = 0; cyc < 100 && feed_idx != 4; cyc++) begin
          @(posedge clk); #2;
        end
        check_eq("reach_byte2", feed_idx, 4);
        reset = 1'b1;
        abort_feed = 1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_ctl", {read, out_valid, out_last, pkt_done, pkt_err}, 0);
        check_eq("mid_rst_dat", {out_data, pkt_da, pkt_sa, pkt_len}, 0);
        check_eq("mid_rst_cnt", {pkt_cnt, err_cnt}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #2;
    check_eq("mid_rst_no_done", done_cnt, 0);

    start_test();
    feed_q = '{8'h0D, 8'h0E, 8'h01, 8'h77, 8'h75};
    exp_q  = '{8'h77};
    feed();
    wait_done(1);
    check_pkt(1'b0, 8'h0D, 8'h0E, 8'h01, 1, 0);
    check_out();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
